// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: edge-detects rx_done, stores bytes first-word-fall-through; optional sticky overrun via UART_RX_FIFO_OVERRUN_EN.
// Latency: a byte accepted at edge N is on dout with empty=0 right after edge N.
// Backpressure: none toward the receiver; a push while full and not popping is dropped.
module uart_rx_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     rx_data,
  input  logic                      rx_done,
  input  logic                      pop,
  input  logic                      overrun_clr,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  rx_done_d;
  logic                  push;
  logic                  do_push;
  logic                  do_pop;
  logic [CW-1:0]         count_nxt;

  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  always_comb begin
    push      = rx_done & ~rx_done_d;
    do_pop    = pop & ~empty;
    do_push   = push & (~full | do_pop);
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_done_d <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
    end else begin
      rx_done_d <= rx_done;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      empty     <= (count_nxt == '0);
      full      <= (count_nxt == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rx_data;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

`ifdef UART_RX_FIFO_OVERRUN_EN
  logic drop;
  assign drop = push & full & ~do_pop;

  // Set wins over clear so a drop in the clearing cycle is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end
`else
  logic unused_overrun_clr;
  assign unused_overrun_clr = overrun_clr;
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model plus directed literal checks.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_done = 1'b0;
  logic          pop = 1'b0;
  logic          overrun_clr = 1'b0;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;
  logic [4:0]    count;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

`ifdef UART_RX_FIFO_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .pop(pop),
    .overrun_clr(overrun_clr), .dout(dout), .empty(empty), .full(full),
    .count(count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of accepted bytes, pop applied before push each edge.
  logic [DW-1:0] mq[$];
  bit            m_prev_done = 1'b0;
  bit            m_ovr = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_prev_done = 1'b0;
      m_ovr = 1'b0;
    end else begin
      bit strobe;
      bit dropped;
      strobe  = rx_done && !m_prev_done;
      dropped = 1'b0;
      m_prev_done = rx_done;
      if (pop && mq.size() > 0) void'(mq.pop_front());
      if (strobe) begin
        if (mq.size() < DEPTH) mq.push_back(rx_data);
        else dropped = 1'b1;
      end
      if (OVR_EN) begin
        if (dropped) m_ovr = 1'b1;
        else if (overrun_clr) m_ovr = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en && rst) begin
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_empty", 32'(empty), 32'(mq.size() == 0));
      chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
      chk("m_dout", 32'(dout), (mq.size() == 0) ? 32'h0 : 32'(mq[0]));
      chk("m_overrun", 32'(overrun), 32'(m_ovr));
      if (count > 5'd16) chk("count_bound", 32'(count), 32'd16);
    end
  end

  // Drive one cycle of inputs, return just after the following falling edge.
  task automatic cyc(input bit d, input logic [DW-1:0] data, input bit p, input bit clr);
    rx_done     = d;
    rx_data     = data;
    pop         = p;
    overrun_clr = clr;
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [DW-1:0] data);
    cyc(1'b1, data, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b1;
    check_en = 1'b1;

    // rx_done high on the first edge after release is a push.
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5_count", 32'(count), 32'd1);
    chk("a5_empty", 32'(empty), 32'd0);
    chk("a5_dout", 32'(dout), 32'hA5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("a5_pop_empty", 32'(empty), 32'd1);
    chk("a5_pop_dout", 32'(dout), 32'd0);

    // Pop on empty is ignored.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop_empty_count", 32'(count), 32'd0);

    // Wide strobe counts once.
    repeat (5) cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("wide_count", 32'(count), 32'd1);
    chk("wide_dout", 32'(dout), 32'h3C);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) push_byte(DW'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    push_byte(8'hFF);
    chk("drop_count", 32'(count), 32'd16);
    chk("drop_overrun", 32'(overrun), 32'(OVR_EN));
    // Drop and clear together keeps overrun set; a lone clear releases it.
    cyc(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("setclr_overrun", 32'(overrun), 32'(OVR_EN));
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_overrun", 32'(overrun), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("drain_dout", 32'(dout), 32'(i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Push with pop at full: no drop, count stays at DEPTH.
    for (int i = 0; i < 16; i++) push_byte(DW'(8'h10 + i));
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("full_pp_count", 32'(count), 32'd16);
    chk("full_pp_overrun", 32'(overrun), 32'd0);
    chk("full_pp_dout", 32'(dout), 32'h11);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("last_dout", 32'(dout), 32'h77);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("pp_drain_empty", 32'(empty), 32'd1);

    // Simultaneous push and pop on empty: push wins, count 1.
    cyc(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("empty_pp_count", 32'(count), 32'd1);
    chk("empty_pp_dout", 32'(dout), 32'h5A);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Random interleave to wrap pointers; the model checks every cycle.
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, DW'($urandom_range(255)), 1'($urandom_range(1)), 1'b0);
      cyc(1'b0, 8'h00, 1'($urandom_range(1)), 1'b0);
    end
    for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rand_empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-cycle with 5 entries stored.
    for (int i = 0; i < 5; i++) push_byte(DW'(8'h40 + i));
    chk("pre_rst_count", 32'(count), 32'd5);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst_count", 32'(count), 32'd0);
    push_byte(8'hC3);
    chk("post_rst_dout", 32'(dout), 32'hC3);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
